// File: rtl/fir_decimator_fifo_if.sv
// Handshake bundle between the FIR result stream, the decimator FIFO and its consumer.
interface fir_decimator_fifo_if #(
    parameter int DATA_W     = 10,
    parameter int FIFO_DEPTH = 4
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic [DATA_W-1:0] i_data;
    logic              i_en;
    logic [DATA_W-1:0] o_data;
    logic              o_valid;
    logic              i_ready;
    logic [LVL_W-1:0]  o_level;
    logic              o_overflow;

    modport master (
        output i_data, i_en, i_ready,
        input  o_data, o_valid, o_level, o_overflow
    );

    modport slave (
        input  i_data, i_en, i_ready,
        output o_data, o_valid, o_level, o_overflow
    );
endinterface

// File: rtl/fir_decimator_fifo.sv
// Accumulate-and-dump decimator (floor average of DECIM samples) feeding a small
// output FIFO drained over a valid/ready handshake, with a sticky overflow flag.
module fir_decimator_fifo #(
    parameter int DATA_W     = 10,
    parameter int DECIM      = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                i_clk,
    input  logic                i_rst,
    fir_decimator_fifo_if.slave bus
);
    localparam int SH    = $clog2(DECIM);
    localparam int ACC_W = DATA_W + SH;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [SH-1:0]    LAST_PH  = SH'(DECIM - 1);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

    function automatic logic [DATA_W-1:0] floor_avg(input logic [ACC_W-1:0] sum);
        return sum[ACC_W-1:SH];
    endfunction

    // Stage p0: accumulate; the dump edge produces the average combinationally
    logic [ACC_W-1:0]  acc_p0;
    logic [SH-1:0]     phase_p0;
    logic [ACC_W-1:0]  sum_p0;
    logic              vld_p0;
    logic [DATA_W-1:0] avg_p0;

    always_comb begin
        sum_p0 = acc_p0 + ACC_W'(bus.i_data);
        vld_p0 = bus.i_en && (phase_p0 == LAST_PH);
        avg_p0 = floor_avg(sum_p0);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            acc_p0   <= '0;
            phase_p0 <= '0;
        end else if (bus.i_en) begin
            if (vld_p0) begin
                acc_p0   <= '0;
                phase_p0 <= '0;
            end else begin
                acc_p0   <= sum_p0;
                phase_p0 <= phase_p0 + 1'b1;
            end
        end
    end

    // Stage p1: output FIFO with a registered head so o_data never depends on i_ready
    logic [DATA_W-1:0] mem_p1 [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_p1;
    logic [PTR_W-1:0]  rd_ptr_p1;
    logic [LVL_W-1:0]  level_p1;
    logic              vld_p1;
    logic [DATA_W-1:0] data_p1;
    logic              ovf_p1;

    logic              pop;
    logic              full;
    logic              push_ok;
    logic              drop;
    logic [PTR_W-1:0]  rd_ptr_nxt;
    logic [LVL_W-1:0]  level_nxt;
    logic [LVL_W-1:0]  remain;
    logic [DATA_W-1:0] data_nxt;

    always_comb begin
        pop        = vld_p1 && bus.i_ready;
        full       = (level_p1 == FULL_LVL);
        // a pop on the same edge frees the slot, so a full FIFO still accepts
        push_ok    = vld_p0 && (!full || pop);
        drop       = vld_p0 && full && !pop;
        rd_ptr_nxt = rd_ptr_p1 + PTR_W'(pop);
        remain     = level_p1 - LVL_W'(pop);
        level_nxt  = remain + LVL_W'(push_ok);
        data_nxt   = data_p1;
        if (remain != '0) begin
            data_nxt = mem_p1[rd_ptr_nxt];
        end else if (push_ok) begin
            data_nxt = avg_p0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push_ok) begin
            mem_p1[wr_ptr_p1] <= avg_p0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_p1 <= '0;
            rd_ptr_p1 <= '0;
            level_p1  <= '0;
            vld_p1    <= 1'b0;
            data_p1   <= '0;
            ovf_p1    <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_p1 <= wr_ptr_p1 + 1'b1;
            end
            rd_ptr_p1 <= rd_ptr_nxt;
            level_p1  <= level_nxt;
            vld_p1    <= (level_nxt != '0);
            data_p1   <= data_nxt;
            if (drop) begin
                ovf_p1 <= 1'b1;
            end
        end
    end

    assign bus.o_data     = data_p1;
    assign bus.o_valid    = vld_p1;
    assign bus.o_level    = level_p1;
    assign bus.o_overflow = ovf_p1;
endmodule

// File: doc/fir_decimator_fifo.md
Name: fir_decimator_fifo

Overview:
Downstream stage of the FIR filter. It consumes the filter's 10-bit result stream (one sample per i_clk while i_en is high) and performs accumulate-and-dump decimation by DECIM, outputting the floor average of each block. Averages are buffered in a small FIFO and drained through a valid/ready handshake to the next consumer (logger/UART framer). Overflow is flagged when the consumer stalls too long.

Parameters:
DATA_W, 10, width of input result and output average (unsigned)
DECIM, 4, decimation factor; power of two, 2..16
FIFO_DEPTH, 4, output FIFO entries; power of two, 2..16

Ports:
i_clk  input  1  clock; all state updates on rising edge
i_rst  input  1  synchronous, active-high reset
i_data  input  DATA_W  filter result sample
i_en  input  1  i_data is a valid sample this cycle
o_data  output  DATA_W  FIFO head (average); meaningful only when o_valid=1
o_valid  output  1  FIFO non-empty
i_ready  input  1  consumer accepts o_data this cycle
o_level  output  clog2(FIFO_DEPTH)+1  current FIFO occupancy
o_overflow  output  1  sticky: an average was dropped because the FIFO was full

Behaviour:
- Reset (i_rst=1 at an edge): accumulator=0, phase=0, FIFO emptied, o_valid=0, o_data=0, o_level=0, o_overflow=0. Reset overrides every other input in that cycle. A partial block in progress is discarded.
- Accumulator width: DATA_W+log2(DECIM); no internal overflow is possible.
- Phase counter 0..DECIM-1 advances only on edges where i_en=1. When i_en=0, accumulator and phase hold.
- Edge with i_en=1 and phase<DECIM-1: acc<=acc+i_data; phase<=phase+1.
- Edge with i_en=1 and phase=DECIM-1 (dump): avg=(acc+i_data)>>log2(DECIM), truncated (floor); push avg; acc<=0; phase<=0.
- Latency: avg is visible at o_data/o_valid immediately after the dump edge (1 cycle after the final sample is presented), provided the FIFO was empty.
- Pop happens on an edge where o_valid=1 and i_ready=1. i_ready while o_valid=0 is ignored.
- o_data is always the oldest entry; it is stable while o_valid=1 and i_ready=0. When empty, o_data holds its last value (0 after reset).
- Push and pop at the same edge: both occur and o_level is unchanged. This also applies when full, in which case the new avg is accepted and no overflow occurs.
- Push while full without a pop: the new avg is dropped, FIFO contents are unchanged, and o_overflow<=1 and stays set until reset.
- Pointers wrap modulo FIFO_DEPTH. o_level ranges 0..FIFO_DEPTH.
- Fully registered outputs; no combinational path from i_ready to o_valid/o_data.

Test Plan:
- Basic average (DECIM=4): reset, i_ready=1, i_en=1, i_data 10,20,30,40 → one cycle after the 40 edge, o_valid=1 for one cycle with o_data=25; o_overflow=0.
- Full-scale and truncation: 1023×4 → 1023. Then 1,1,1,2 → 1 (5>>2). i_en low for 3 cycles mid-block (between the 2nd and 3rd sample) → same results, phase holds.
- Backpressure/overflow: i_ready=0, five blocks of constants 100,200,300,400,500 → o_level=4, o_overflow=1. Then i_ready=1 → outputs 100,200,300,400 on consecutive cycles; 500 is never seen; o_overflow stays 1.
- Simultaneous push/pop when full: FIFO full (o_level=4), dump edge coincides with i_ready=1 → o_level stays 4, o_overflow=0, new average emerges last in order.
- Reset mid-block: feed 2 samples of 800, assert i_rst for one cycle, then feed 4 samples of 8 → single output 8 (the partial block is discarded); o_valid=0 and o_level=0 right after reset.
- Random soak: 2000 random i_data/i_en/i_ready values against a reference model → every popped value matches in order; o_overflow is set exactly when the model drops an average.
